// File: rtl/kim_fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package kim_fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FULL  = 2'd2
   } fetch_state_t;

   localparam int INSTR_WIDTH = 32;
   localparam int PC_STEP     = 4;
   localparam int BUF_DEPTH   = 2;

endpackage

// File: rtl/kim_fetch_skid_buf.sv
// Two-entry FIFO of {instr, pc}; entry 0 is the head and drives the outputs directly.
// Push/pop/flush take effect on the edge; the head holds its last value when empty.
module kim_fetch_skid_buf
   import kim_fetch_pkg::*;
#(
   parameter int IW = INSTR_WIDTH,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [IW-1:0] push_instr,
   input  logic [AW-1:0] push_pc,
   input  logic          pop,
   input  logic          flush,
   output logic [1:0]    count,
   output logic [IW-1:0] head_instr,
   output logic [AW-1:0] head_pc
);

   logic [IW-1:0] tail_instr;
   logic [AW-1:0] tail_pc;

   // Shift-style storage: a pop moves the tail into the head, so the head
   // registers are never overwritten by stale data when the buffer empties.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count      <= 2'd0;
         head_instr <= '0;
         head_pc    <= '0;
         tail_instr <= '0;
         tail_pc    <= '0;
      end else if (flush) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count == 2'd0) begin
                  head_instr <= push_instr;
                  head_pc    <= push_pc;
                  count      <= 2'd1;
               end else begin
                  tail_instr <= push_instr;
                  tail_pc    <= push_pc;
                  count      <= 2'd2;
               end
            end
            2'b01: begin
               if (count == 2'd2) begin
                  head_instr <= tail_instr;
                  head_pc    <= tail_pc;
               end
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  head_instr <= tail_instr;
                  head_pc    <= tail_pc;
                  tail_instr <= push_instr;
                  tail_pc    <= push_pc;
               end else begin
                  head_instr <= push_instr;
                  head_pc    <= push_pc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/kim_fetch_ctrl_p.sv
// Fetch controller: owns the PC, reads combinational imem, buffers words for decode.
// First instruction visible 2 edges after fetch_en; stalls in FULL while out_ready is low.
module kim_fetch_ctrl_p
   import kim_fetch_pkg::*;
#(
   parameter int                         MEM_ADDR_WIDTH = 6,
   parameter int                         MEM_DATA_WIDTH = 8,
   parameter logic [MEM_ADDR_WIDTH-1:0]  RESET_PC       = '0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          fetch_en,
   input  logic                          redirect_valid,
   input  logic [MEM_ADDR_WIDTH-1:0]     redirect_pc,
   output logic [MEM_ADDR_WIDTH-1:0]     r_addr_by_pc,
   input  logic [MEM_DATA_WIDTH*4-1:0]   mem_instruction,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [MEM_DATA_WIDTH*4-1:0]   out_instr,
   output logic [MEM_ADDR_WIDTH-1:0]     out_pc,
   output logic [15:0]                   fetch_cnt
);

   localparam int IW = MEM_DATA_WIDTH * 4;
   localparam int AW = MEM_ADDR_WIDTH;

   fetch_state_t  state, state_nxt;
   logic [AW-1:0] pc;
   logic [1:0]    count;
   logic          pop, space, push;

   assign out_valid    = (count != 2'd0);
   assign pop          = out_valid & out_ready;
   assign space        = (count < 2'(BUF_DEPTH)) | pop;
   assign r_addr_by_pc = pc;

   always_comb begin
      push      = 1'b0;
      state_nxt = state;
      if (redirect_valid) begin
         state_nxt = fetch_en ? FETCH : IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (fetch_en) state_nxt = FETCH;
            end
            FETCH: begin
               if (!fetch_en) begin
                  state_nxt = IDLE;
               end else begin
                  push = space;
                  // Count lands on 2 only when nothing left and the buffer was not already empty.
                  if (!pop && (count == 2'd2 || (count == 2'd1 && space)))
                     state_nxt = FULL;
               end
            end
            FULL: begin
               if (!fetch_en)  state_nxt = IDLE;
               else if (pop)   state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         fetch_cnt <= 16'd0;
      end else begin
         state <= state_nxt;
         if (redirect_valid)
            pc <= redirect_pc & ~AW'(3);
         else if (push)
            pc <= pc + AW'(PC_STEP);
         if (push)
            fetch_cnt <= fetch_cnt + 16'd1;
      end
   end

   kim_fetch_skid_buf #(
      .IW (IW),
      .AW (AW)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_instr (mem_instruction),
      .push_pc    (pc),
      .pop        (pop),
      .flush      (redirect_valid),
      .count      (count),
      .head_instr (out_instr),
      .head_pc    (out_pc)
   );

endmodule

// File: tb/tb_kim_fetch_ctrl_p.sv
// Bench for kim_fetch_ctrl_p: queue-based reference model checked every cycle,
// directed scenarios with literal pins, then randomized traffic.
module tb_kim_fetch_ctrl_p;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [5:0]  redirect_pc = 6'd0;
   logic        out_ready = 1'b0;
   logic [5:0]  r_addr_by_pc;
   logic [31:0] mem_instruction;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [5:0]  out_pc;
   logic [15:0] fetch_cnt;

   logic [7:0]  mem [64];

   int total = 0;
   int bad   = 0;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_STALL = 2;

   int          m_mode;
   logic [5:0]  m_pc;
   logic [31:0] q_instr [$];
   logic [5:0]  q_pc [$];
   logic [31:0] m_last_instr;
   logic [5:0]  m_last_pc;
   logic [15:0] m_cnt;

   always #5 clk = ~clk;

   assign mem_instruction = {mem[r_addr_by_pc + 6'd3], mem[r_addr_by_pc + 6'd2],
                             mem[r_addr_by_pc + 6'd1], mem[r_addr_by_pc]};

   kim_fetch_ctrl_p #(
      .MEM_ADDR_WIDTH (6),
      .MEM_DATA_WIDTH (8),
      .RESET_PC       (6'd0)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fetch_en        (fetch_en),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .r_addr_by_pc    (r_addr_by_pc),
      .mem_instruction (mem_instruction),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .fetch_cnt       (fetch_cnt)
   );

   function automatic logic [31:0] word_at(input logic [5:0] p);
      logic [5:0] b0, b1, b2, b3;
      b0 = p; b1 = p + 6'd1; b2 = p + 6'd2; b3 = p + 6'd3;
      return {mem[b3], mem[b2], mem[b1], mem[b0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_pc = 6'd0;
      q_instr.delete();
      q_pc.delete();
      m_last_instr = 32'd0;
      m_last_pc = 6'd0;
      m_cnt = 16'd0;
   endtask

   // One clock edge of the fetch rules, using the inputs present at that edge.
   task automatic model_step();
      bit pop;
      bit space;
      pop = (q_pc.size() > 0) && out_ready;
      if (redirect_valid) begin
         q_instr.delete();
         q_pc.delete();
         m_pc = redirect_pc & 6'h3C;
         m_mode = fetch_en ? M_RUN : M_IDLE;
      end else begin
         space = (q_pc.size() < 2) || pop;
         if (pop) begin
            void'(q_instr.pop_front());
            void'(q_pc.pop_front());
         end
         case (m_mode)
            M_IDLE: if (fetch_en) m_mode = M_RUN;
            M_RUN: begin
               if (!fetch_en) begin
                  m_mode = M_IDLE;
               end else begin
                  if (space) begin
                     q_instr.push_back(word_at(m_pc));
                     q_pc.push_back(m_pc);
                     m_pc = m_pc + 6'd4;
                     m_cnt = m_cnt + 16'd1;
                  end
                  if (q_pc.size() == 2 && !pop) m_mode = M_STALL;
               end
            end
            default: begin
               if (!fetch_en) m_mode = M_IDLE;
               else if (pop)  m_mode = M_RUN;
            end
         endcase
      end
      if (q_pc.size() > 0) begin
         m_last_instr = q_instr[0];
         m_last_pc = q_pc[0];
      end
   endtask

   task automatic compare_all();
      chk("addr",  {26'd0, r_addr_by_pc}, {26'd0, m_pc});
      chk("valid", {31'd0, out_valid}, (q_pc.size() > 0) ? 32'd1 : 32'd0);
      chk("out_pc", {26'd0, out_pc}, {26'd0, m_last_pc});
      chk("instr", out_instr, m_last_instr);
      chk("cnt", {16'd0, fetch_cnt}, {16'd0, m_cnt});
   endtask

   // Called at a falling edge: apply inputs, clock once, check at next falling edge.
   task automatic cyc(input logic fe, input logic rv, input logic [5:0] rpc, input logic ordy);
      fetch_en = fe;
      redirect_valid = rv;
      redirect_pc = rpc;
      out_ready = ordy;
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   // Reset pulse entirely between two rising edges.
   task automatic rst_pulse();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_addr", {26'd0, r_addr_by_pc}, 32'd0);
      chk("rst_cnt", {16'd0, fetch_cnt}, 32'd0);
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'(i);
      model_reset();

      // Reset state
      repeat (2) @(negedge clk);
      compare_all();
      chk("reset_instr", out_instr, 32'd0);
      rst_n = 1'b1;

      // Free-running fetch with decode always ready
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
      chk("s1_no_valid_yet", {31'd0, out_valid}, 32'd0);
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
      chk("s1_first_valid", {31'd0, out_valid}, 32'd1);
      chk("s1_first_pc", {26'd0, out_pc}, 32'h00);
      chk("s1_first_instr", out_instr, 32'h03020100);
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
      chk("s1_second_pc", {26'd0, out_pc}, 32'h04);
      chk("s1_cnt", {16'd0, fetch_cnt}, 32'd2);
      repeat (4) cyc(1'b1, 1'b0, 6'd0, 1'b1);

      // Backpressure from a clean start: two pushes then stall
      rst_pulse();
      repeat (6) cyc(1'b1, 1'b0, 6'd0, 1'b0);
      chk("s2_pc_stop", {26'd0, r_addr_by_pc}, 32'h08);
      chk("s2_cnt", {16'd0, fetch_cnt}, 32'd2);
      chk("s2_head", {26'd0, out_pc}, 32'h00);
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
      chk("s2_drain_4", {26'd0, out_pc}, 32'h04);
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
      chk("s2_drain_8", {26'd0, out_pc}, 32'h08);

      // Redirect while full, coincident with a pop
      cyc(1'b1, 1'b1, 6'd0, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 6'd0, 1'b0);
      cyc(1'b1, 1'b1, 6'h23, 1'b1);
      chk("s3_flush_valid", {31'd0, out_valid}, 32'd0);
      chk("s3_new_pc", {26'd0, r_addr_by_pc}, 32'h20);
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
      chk("s3_first_pc", {26'd0, out_pc}, 32'h20);

      // PC wrap from the top word
      cyc(1'b1, 1'b1, 6'h3C, 1'b1);
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
      chk("s4_top_pc", {26'd0, out_pc}, 32'h3C);
      chk("s4_wrap_addr", {26'd0, r_addr_by_pc}, 32'h00);
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
      chk("s4_wrap_pc", {26'd0, out_pc}, 32'h00);
      chk("s4_wrap_instr", out_instr, 32'h03020100);

      // Stop fetching with one entry buffered, then drain
      cyc(1'b1, 1'b1, 6'h10, 1'b1);
      cyc(1'b1, 1'b0, 6'd0, 1'b0);
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk("s5_held_valid", {31'd0, out_valid}, 32'd1);
      chk("s5_held_pc", {26'd0, out_pc}, 32'h10);
      cyc(1'b0, 1'b0, 6'd0, 1'b1);
      chk("s5_drained", {31'd0, out_valid}, 32'd0);
      chk("s5_addr", {26'd0, r_addr_by_pc}, 32'h14);
      cyc(1'b0, 1'b0, 6'd0, 1'b1);
      chk("s5_idle_hold_pc", {26'd0, out_pc}, 32'h10);

      // Reset mid-stream then restart
      repeat (3) cyc(1'b1, 1'b0, 6'd0, 1'b1);
      rst_pulse();
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
      chk("s6_no_valid_yet", {31'd0, out_valid}, 32'd0);
      cyc(1'b1, 1'b0, 6'd0, 1'b1);
      chk("s6_first_pc", {26'd0, out_pc}, 32'h00);
      chk("s6_cnt", {16'd0, fetch_cnt}, 32'd1);

      // Randomized traffic
      for (int n = 0; n < 2000; n++) begin
         if (n == 1000) rst_pulse();
         cyc($urandom_range(0, 9) != 0,
             $urandom_range(0, 15) == 0,
             6'($urandom),
             1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
